// File: rtl/banco_arbitro.sv
// Round-robin arbiter/sequencer between two requesters and the 8x16 register bank.
// One access is in flight at a time: IDLE -> READ/WRITE -> RESP -> IDLE.
module banco_arbitro #(
    parameter int BITS_PALAVRA  = 16,
    parameter int END_REGISTROS = 3
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     p0_req_valid,
    output logic                     p0_req_ready,
    input  logic                     p0_req_we,
    input  logic [END_REGISTROS-1:0] p0_req_addr_a,
    input  logic [END_REGISTROS-1:0] p0_req_addr_b,
    input  logic [BITS_PALAVRA-1:0]  p0_req_wdata,
    output logic                     p0_rsp_valid,
    input  logic                     p0_rsp_ready,
    input  logic                     p1_req_valid,
    output logic                     p1_req_ready,
    input  logic                     p1_req_we,
    input  logic [END_REGISTROS-1:0] p1_req_addr_a,
    input  logic [END_REGISTROS-1:0] p1_req_addr_b,
    input  logic [BITS_PALAVRA-1:0]  p1_req_wdata,
    output logic                     p1_rsp_valid,
    input  logic                     p1_rsp_ready,
    output logic                     rsp_we,
    output logic [BITS_PALAVRA-1:0]  rsp_a,
    output logic [BITS_PALAVRA-1:0]  rsp_b,
    output logic                     bank_hab_escrita,
    output logic [END_REGISTROS-1:0] bank_sel_e_sa,
    output logic [END_REGISTROS-1:0] bank_sel_sb,
    output logic [BITS_PALAVRA-1:0]  bank_e,
    input  logic [BITS_PALAVRA-1:0]  bank_a,
    input  logic [BITS_PALAVRA-1:0]  bank_b,
    output logic                     busy
);

    typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

    state_t                   state_q, state_d;
    logic                     prio_q, prio_d;
    logic                     owner_q, owner_d;
    logic                     rsp_we_q, rsp_we_d;
    logic [END_REGISTROS-1:0] addr_a_q, addr_a_d;
    logic [END_REGISTROS-1:0] addr_b_q, addr_b_d;
    logic [BITS_PALAVRA-1:0]  wdata_q, wdata_d;
    logic [BITS_PALAVRA-1:0]  rsp_a_q, rsp_a_d;
    logic [BITS_PALAVRA-1:0]  rsp_b_q, rsp_b_d;

    logic grant;
    logic accept;
    logic sel_we;

    // Priority port wins a tie; an idle grant rests on the priority port.
    always_comb begin
        grant = prio_q;
        if (prio_q ? p1_req_valid : p0_req_valid)
            grant = prio_q;
        else if (prio_q ? p0_req_valid : p1_req_valid)
            grant = ~prio_q;
        accept = (state_q == IDLE) && (grant ? p1_req_valid : p0_req_valid);
        sel_we = grant ? p1_req_we : p0_req_we;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            prio_q   <= 1'b0;
            owner_q  <= 1'b0;
            rsp_we_q <= 1'b0;
            addr_a_q <= '0;
            addr_b_q <= '0;
            wdata_q  <= '0;
            rsp_a_q  <= '0;
            rsp_b_q  <= '0;
        end else begin
            state_q  <= state_d;
            prio_q   <= prio_d;
            owner_q  <= owner_d;
            rsp_we_q <= rsp_we_d;
            addr_a_q <= addr_a_d;
            addr_b_q <= addr_b_d;
            wdata_q  <= wdata_d;
            rsp_a_q  <= rsp_a_d;
            rsp_b_q  <= rsp_b_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        prio_d   = prio_q;
        owner_d  = owner_q;
        rsp_we_d = rsp_we_q;
        addr_a_d = addr_a_q;
        addr_b_d = addr_b_q;
        wdata_d  = wdata_q;
        rsp_a_d  = rsp_a_q;
        rsp_b_d  = rsp_b_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    owner_d  = grant;
                    prio_d   = ~grant;
                    addr_a_d = grant ? p1_req_addr_a : p0_req_addr_a;
                    addr_b_d = grant ? p1_req_addr_b : p0_req_addr_b;
                    wdata_d  = grant ? p1_req_wdata  : p0_req_wdata;
                    state_d  = sel_we ? WRITE : READ;
                end
            end
            // The bank has already acted on the negedge inside this cycle.
            READ: begin
                rsp_a_d  = bank_a;
                rsp_b_d  = bank_b;
                rsp_we_d = 1'b0;
                state_d  = RESP;
            end
            WRITE: begin
                rsp_a_d  = '0;
                rsp_b_d  = '0;
                rsp_we_d = 1'b1;
                state_d  = RESP;
            end
            RESP: begin
                if (owner_q ? p1_rsp_ready : p0_rsp_ready)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        p0_req_ready     = (state_q == IDLE) && !grant;
        p1_req_ready     = (state_q == IDLE) && grant;
        p0_rsp_valid     = (state_q == RESP) && !owner_q;
        p1_rsp_valid     = (state_q == RESP) && owner_q;
        busy             = (state_q != IDLE);
        bank_hab_escrita = (state_q == WRITE);
        bank_sel_e_sa    = addr_a_q;
        bank_sel_sb      = addr_b_q;
        bank_e           = wdata_q;
        rsp_we           = rsp_we_q;
        rsp_a            = rsp_a_q;
        rsp_b            = rsp_b_q;
    end

endmodule

// File: tb/tb_banco_arbitro.sv
// Self-checking bench for banco_arbitro with a negedge register-bank model and a
// response scoreboard fed from a reference copy of the register contents.
module tb_banco_arbitro;

    logic        clock = 1'b0;
    logic        reset;
    logic        p0_req_valid, p0_req_ready, p0_req_we, p0_rsp_valid, p0_rsp_ready;
    logic [2:0]  p0_req_addr_a, p0_req_addr_b;
    logic [15:0] p0_req_wdata;
    logic        p1_req_valid, p1_req_ready, p1_req_we, p1_rsp_valid, p1_rsp_ready;
    logic [2:0]  p1_req_addr_a, p1_req_addr_b;
    logic [15:0] p1_req_wdata;
    logic        rsp_we, bank_hab_escrita, busy;
    logic [15:0] rsp_a, rsp_b, bank_e, bank_a, bank_b;
    logic [2:0]  bank_sel_e_sa, bank_sel_sb;

    typedef struct {
        int          port;
        logic        we;
        logic [15:0] a;
        logic [15:0] b;
    } exp_t;

    exp_t        sb_q[$];
    logic [15:0] ref_mem [8];
    logic [15:0] bank_mem [8];
    int          pass_count = 0;
    int          total_count = 0;

    banco_arbitro #(.BITS_PALAVRA(16), .END_REGISTROS(3)) dut (
        .clock(clock), .reset(reset),
        .p0_req_valid(p0_req_valid), .p0_req_ready(p0_req_ready), .p0_req_we(p0_req_we),
        .p0_req_addr_a(p0_req_addr_a), .p0_req_addr_b(p0_req_addr_b),
        .p0_req_wdata(p0_req_wdata), .p0_rsp_valid(p0_rsp_valid), .p0_rsp_ready(p0_rsp_ready),
        .p1_req_valid(p1_req_valid), .p1_req_ready(p1_req_ready), .p1_req_we(p1_req_we),
        .p1_req_addr_a(p1_req_addr_a), .p1_req_addr_b(p1_req_addr_b),
        .p1_req_wdata(p1_req_wdata), .p1_rsp_valid(p1_rsp_valid), .p1_rsp_ready(p1_rsp_ready),
        .rsp_we(rsp_we), .rsp_a(rsp_a), .rsp_b(rsp_b),
        .bank_hab_escrita(bank_hab_escrita), .bank_sel_e_sa(bank_sel_e_sa),
        .bank_sel_sb(bank_sel_sb), .bank_e(bank_e), .bank_a(bank_a), .bank_b(bank_b),
        .busy(busy)
    );

    always #5 clock = ~clock;

    // Register bank: writes and latches its A/B outputs on the falling edge.
    always @(negedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 8; i++) bank_mem[i] <= 16'h0000;
            bank_a <= 16'h0000;
            bank_b <= 16'h0000;
        end else begin
            if (bank_hab_escrita) bank_mem[bank_sel_e_sa] <= bank_e;
            bank_a <= bank_mem[bank_sel_e_sa];
            bank_b <= bank_mem[bank_sel_sb];
        end
    end

    task automatic drive_req(input int port, input logic v, input logic we,
                             input logic [2:0] a, input logic [2:0] b, input logic [15:0] wd);
        if (port == 0) begin
            p0_req_valid = v; p0_req_we = we; p0_req_addr_a = a; p0_req_addr_b = b; p0_req_wdata = wd;
        end else begin
            p1_req_valid = v; p1_req_we = we; p1_req_addr_a = a; p1_req_addr_b = b; p1_req_wdata = wd;
        end
    endtask

    task automatic push_expected(input int port, input logic we, input logic [2:0] a,
                                 input logic [2:0] b, input logic [15:0] wd);
        exp_t e;
        e.port = port;
        e.we   = we;
        if (we) begin
            ref_mem[a] = wd;
            e.a = 16'h0000;
            e.b = 16'h0000;
        end else begin
            e.a = ref_mem[a];
            e.b = ref_mem[b];
        end
        sb_q.push_back(e);
    endtask

    function automatic exp_t pop_exp();
        exp_t e;
        e.port = -1; e.we = 1'bx; e.a = 'x; e.b = 'x;
        if (sb_q.size() > 0) e = sb_q.pop_front();
        return e;
    endfunction

    // Called 1 time unit after a posedge; returns 1 time unit after the accept edge.
    task automatic issue(input int port, input logic we, input logic [2:0] a, input logic [2:0] b,
                         input logic [15:0] wd, output logic accepted, output int waits);
        accepted = 1'b0;
        waits    = 0;
        drive_req(port, 1'b1, we, a, b, wd);
        #1;
        for (int i = 0; i < 10; i++) begin
            if ((port == 0) ? p0_req_ready : p1_req_ready) begin
                push_expected(port, we, a, b, wd);
                @(posedge clock); #1;
                accepted = 1'b1;
                break;
            end
            @(posedge clock); #1;
            waits++;
        end
        drive_req(port, 1'b0, 1'b0, 3'd0, 3'd0, 16'h0000);
    endtask

    task automatic wait_rsp(input int port, input int hold, output logic seen, output int latency,
                            output logic [32:0] obs, output int unstable);
        seen = 1'b0; latency = 0; unstable = 0; obs = '0;
        for (int i = 0; i < 12; i++) begin
            if ((port == 0) ? p0_rsp_valid : p1_rsp_valid) begin
                seen = 1'b1;
                break;
            end
            @(posedge clock); #1;
            latency++;
        end
        if (seen) begin
            obs = {rsp_we, rsp_a, rsp_b};
            for (int i = 0; i < hold; i++) begin
                @(posedge clock); #1;
                if (!((port == 0) ? p0_rsp_valid : p1_rsp_valid) || ((port == 0) ? p1_rsp_valid : p0_rsp_valid)
                    || {rsp_we, rsp_a, rsp_b} !== obs || !busy || p0_req_ready || p1_req_ready)
                    unstable++;
            end
            if (port == 0) p0_rsp_ready = 1'b1; else p1_rsp_ready = 1'b1;
            @(posedge clock); #1;
            if (port == 0) p0_rsp_ready = 1'b0; else p1_rsp_ready = 1'b0;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive_req(0, 1'b0, 1'b0, 3'd0, 3'd0, 16'h0000);
        drive_req(1, 1'b0, 1'b0, 3'd0, 3'd0, 16'h0000);
        p0_rsp_ready = 1'b0;
        p1_rsp_ready = 1'b0;
        for (int i = 0; i < 8; i++) ref_mem[i] = 16'h0000;
        #22 reset = 1'b0;
        @(posedge clock); #1;
        total_count++;
        if ({busy, p0_req_ready, p1_req_ready} !== 3'b010)
            $display("[TB] FAIL reset_ready_busy: got %b required 010", {busy, p0_req_ready, p1_req_ready});
        else pass_count++;
        total_count++;
        if ({rsp_we, rsp_a, rsp_b} !== 33'd0)
            $display("[TB] FAIL reset_rsp: got %h required 0", {rsp_we, rsp_a, rsp_b});
        else pass_count++;
        total_count++;
        if ({bank_hab_escrita, p0_rsp_valid, p1_rsp_valid} !== 3'b000)
            $display("[TB] FAIL reset_hab_rspvalid: got %b required 000",
                     {bank_hab_escrita, p0_rsp_valid, p1_rsp_valid});
        else pass_count++;
    endtask

    task automatic test_write_read();
        logic acc, seen; int waits, lat, unst; logic [32:0] obs; exp_t e;
        issue(0, 1'b1, 3'd3, 3'd0, 16'hBEEF, acc, waits);
        total_count++;
        if ({acc, bank_hab_escrita, busy, bank_sel_e_sa, bank_e} !== {3'b111, 3'd3, 16'hBEEF})
            $display("[TB] FAIL write_bank_drive: got %h required %h",
                     {acc, bank_hab_escrita, busy, bank_sel_e_sa, bank_e}, {3'b111, 3'd3, 16'hBEEF});
        else pass_count++;
        wait_rsp(0, 0, seen, lat, obs, unst);
        e = pop_exp();
        total_count++;
        if ({seen, obs} !== {1'b1, e.we, e.a, e.b} || e.port != 0)
            $display("[TB] FAIL write_ack: got %h required %h", {seen, obs}, {1'b1, e.we, e.a, e.b});
        else pass_count++;
        issue(1, 1'b0, 3'd3, 3'd0, 16'h0000, acc, waits);
        wait_rsp(1, 0, seen, lat, obs, unst);
        total_count++;
        if ({acc, seen, lat} !== {2'b11, 32'd1})
            $display("[TB] FAIL read_latency: got acc=%b seen=%b lat=%0d required 1 1 1", acc, seen, lat);
        else pass_count++;
        e = pop_exp();
        total_count++;
        if (obs !== {1'b0, 16'hBEEF, 16'h0000} || obs !== {e.we, e.a, e.b} || e.port != 1)
            $display("[TB] FAIL read_after_write: got %h required %h", obs, {1'b0, 16'hBEEF, 16'h0000});
        else pass_count++;
    endtask

    task automatic test_alternation();
        int grants[$]; int gcyc[$]; int nrsp; int both; exp_t e; logic [33:0] got;
        nrsp = 0; both = 0;
        drive_req(0, 1'b1, 1'b0, 3'd3, 3'd3, 16'h0000);
        drive_req(1, 1'b1, 1'b0, 3'd0, 3'd3, 16'h0000);
        p0_rsp_ready = 1'b1;
        p1_rsp_ready = 1'b1;
        #1;
        for (int cyc = 0; cyc < 40 && nrsp < 4; cyc++) begin
            if (p0_req_ready && p1_req_ready) both++;
            if (p0_rsp_valid || p1_rsp_valid) begin
                e = pop_exp();
                got = {p1_rsp_valid, rsp_we, rsp_a, rsp_b};
                total_count++;
                if (got !== {e.port[0], e.we, e.a, e.b} || e.port < 0)
                    $display("[TB] FAIL alt_rsp%0d: got %h required %h", nrsp, got, {e.port[0], e.we, e.a, e.b});
                else pass_count++;
                nrsp++;
            end
            if (grants.size() < 4 && p0_req_valid && p0_req_ready) begin
                grants.push_back(0); gcyc.push_back(cyc);
                push_expected(0, 1'b0, 3'd3, 3'd3, 16'h0000);
            end else if (grants.size() < 4 && p1_req_valid && p1_req_ready) begin
                grants.push_back(1); gcyc.push_back(cyc);
                push_expected(1, 1'b0, 3'd0, 3'd3, 16'h0000);
            end
            @(posedge clock); #1;
            if (grants.size() == 4) begin
                p0_req_valid = 1'b0;
                p1_req_valid = 1'b0;
            end
        end
        p0_rsp_ready = 1'b0;
        p1_rsp_ready = 1'b0;
        total_count++;
        if (grants.size() != 4 || nrsp != 4 || both != 0)
            $display("[TB] FAIL alt_counts: got grants=%0d rsps=%0d both_ready=%0d required 4 4 0",
                     grants.size(), nrsp, both);
        else pass_count++;
        for (int i = 0; i < grants.size(); i++) begin
            total_count++;
            if (grants[i] != (i % 2) || (i > 0 && gcyc[i] - gcyc[i-1] != 3))
                $display("[TB] FAIL alt_grant%0d: got port=%0d gap=%0d required port=%0d gap=3",
                         i, grants[i], (i > 0) ? gcyc[i] - gcyc[i-1] : 3, i % 2);
            else pass_count++;
        end
    endtask

    task automatic test_hold_rsp();
        logic acc, seen; int waits, lat, unst; logic [32:0] obs; exp_t e;
        issue(0, 1'b1, 3'd7, 3'd0, 16'h1234, acc, waits);
        wait_rsp(0, 0, seen, lat, obs, unst);
        e = pop_exp();
        total_count++;
        if ({acc, seen, obs} !== {2'b11, 1'b1, 32'h0} || {e.we, e.a, e.b} !== {1'b1, 32'h0})
            $display("[TB] FAIL hold_write_ack: got %h required %h", {acc, seen, obs}, {2'b11, 1'b1, 32'h0});
        else pass_count++;
        issue(1, 1'b0, 3'd7, 3'd7, 16'h0000, acc, waits);
        p0_rsp_ready = 1'b1;
        wait_rsp(1, 5, seen, lat, obs, unst);
        p0_rsp_ready = 1'b0;
        e = pop_exp();
        total_count++;
        if ({seen, obs} !== {1'b1, 1'b0, 16'h1234, 16'h1234} || obs !== {e.we, e.a, e.b})
            $display("[TB] FAIL hold_read_data: got %h required %h", {seen, obs}, {1'b1, 1'b0, 16'h1234, 16'h1234});
        else pass_count++;
        total_count++;
        if (unst != 0)
            $display("[TB] FAIL hold_stable: got %0d unstable cycles required 0", unst);
        else pass_count++;
        total_count++;
        if ({busy, p1_rsp_valid, p0_rsp_valid} !== 3'b000)
            $display("[TB] FAIL hold_release_idle: got %b required 000", {busy, p1_rsp_valid, p0_rsp_valid});
        else pass_count++;
    endtask

    task automatic test_reset_mid_write();
        logic acc; int waits; int spurious;
        spurious = 0;
        issue(0, 1'b1, 3'd5, 3'd0, 16'hAAAA, acc, waits);
        total_count++;
        if ({acc, bank_hab_escrita} !== 2'b11)
            $display("[TB] FAIL midrst_in_write: got %b required 11", {acc, bank_hab_escrita});
        else pass_count++;
        #2 reset = 1'b1;
        #1;
        total_count++;
        if ({bank_hab_escrita, busy, p0_rsp_valid, p1_rsp_valid} !== 4'b0000)
            $display("[TB] FAIL midrst_immediate: got %b required 0000",
                     {bank_hab_escrita, busy, p0_rsp_valid, p1_rsp_valid});
        else pass_count++;
        sb_q.delete();
        for (int i = 0; i < 8; i++) ref_mem[i] = 16'h0000;
        @(posedge clock); #3 reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clock); #1;
            if (p0_rsp_valid || p1_rsp_valid || busy) spurious++;
        end
        total_count++;
        if (spurious != 0)
            $display("[TB] FAIL midrst_no_rsp: got %0d active cycles required 0", spurious);
        else pass_count++;
    endtask

    task automatic test_lone_p1();
        logic acc, seen; int waits, lat, unst; logic [32:0] obs; exp_t e;
        total_count++;
        if ({p0_req_ready, p1_req_ready} !== 2'b10)
            $display("[TB] FAIL lone_prio_p0: got %b required 10", {p0_req_ready, p1_req_ready});
        else pass_count++;
        issue(1, 1'b0, 3'd5, 3'd7, 16'h0000, acc, waits);
        total_count++;
        if ({acc, waits} !== {1'b1, 32'd0})
            $display("[TB] FAIL lone_p1_grant: got acc=%b waits=%0d required 1 0", acc, waits);
        else pass_count++;
        wait_rsp(1, 0, seen, lat, obs, unst);
        e = pop_exp();
        total_count++;
        if ({seen, obs} !== {1'b1, 33'd0} || obs !== {e.we, e.a, e.b})
            $display("[TB] FAIL lone_read_cleared: got %h required %h", {seen, obs}, {1'b1, 33'd0});
        else pass_count++;
        drive_req(0, 1'b1, 1'b0, 3'd5, 3'd5, 16'h0000);
        drive_req(1, 1'b1, 1'b0, 3'd7, 3'd7, 16'h0000);
        #1;
        total_count++;
        if ({p0_req_ready, p1_req_ready} !== 2'b10)
            $display("[TB] FAIL tie_after_lone: got %b required 10", {p0_req_ready, p1_req_ready});
        else pass_count++;
        push_expected(0, 1'b0, 3'd5, 3'd5, 16'h0000);
        @(posedge clock); #1;
        drive_req(0, 1'b0, 1'b0, 3'd0, 3'd0, 16'h0000);
        drive_req(1, 1'b0, 1'b0, 3'd0, 3'd0, 16'h0000);
        wait_rsp(0, 0, seen, lat, obs, unst);
        e = pop_exp();
        total_count++;
        if ({seen, lat, obs} !== {1'b1, 32'd1, 33'd0} || obs !== {e.we, e.a, e.b})
            $display("[TB] FAIL tie_p0_rsp: got seen=%b lat=%0d data=%h required 1 1 0", seen, lat, obs);
        else pass_count++;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_write_read();
        test_alternation();
        test_hold_rsp();
        test_reset_mid_write();
        test_lone_p1();
        $display("%0d/%0d checks passed", pass_count, total_count);
        $finish;
    end

endmodule
